alu_operand_stage: RTL and testbench

Registered, parametrised operand-staging block for the ALU input side. It replaces a plain combinational source mux. Each of the two ALU operands (A and B) is captured independently from N packed register sources or from three built-in constants. A valid/ready handshake then presents the operand pair to the ALU. The block sits between the register file/flag/stack sources and the ALU, and is driven by the control unit's load strobes.

---
 rtl/cpu_operand_pkg.sv | 25 ++
 rtl/alu_operand_stage_if.sv | 29 ++
 rtl/operand_select.sv | 35 +++
 rtl/alu_operand_stage.sv | 92 +++++++++
 tb/tb_alu_operand_stage.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_operand_pkg.sv
// Shared types and constant-code offsets for the ALU operand staging path.
package cpu_operand_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StHaveA = 2'd1,
    StHaveB = 2'd2,
    StFull  = 2'd3
  } op_state_e;

  // Constant select codes sit directly above the last register source.
  localparam int unsigned SEL_ZERO_OFS = 0;
  localparam int unsigned SEL_ONE_OFS  = 1;
  localparam int unsigned SEL_ONES_OFS = 2;

  function automatic op_state_e state_from_flags(input logic has_a, input logic has_b);
    unique case ({has_a, has_b})
      2'b00:   return StEmpty;
      2'b10:   return StHaveA;
      2'b01:   return StHaveB;
      default: return StFull;
    endcase
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Handshake/bus bundle between the control unit, the operand stage and the ALU.
interface alu_operand_stage_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NSRC  = 6
) ();
  localparam int unsigned SEL_W = $clog2(NSRC + 3);

  logic [NSRC*WIDTH-1:0] src_bus;
  logic [SEL_W-1:0]      sel_a;
  logic [SEL_W-1:0]      sel_b;
  logic                  load_a;
  logic                  load_b;
  logic                  flush;
  logic                  alu_ready;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic                  op_valid;
  logic                  sel_err;

  modport master (
    output src_bus, sel_a, sel_b, load_a, load_b, flush, alu_ready,
    input  alu_a, alu_b, op_valid, sel_err
  );

  modport slave (
    input  src_bus, sel_a, sel_b, load_a, load_b, flush, alu_ready,
    output alu_a, alu_b, op_valid, sel_err
  );
endinterface

// File: rtl/operand_select.sv
// Combinational operand decode: register source, built-in constant, or out-of-range.
module operand_select
  import cpu_operand_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NSRC  = 6,
  parameter int unsigned SEL_W = $clog2(NSRC + 3)
) (
  input  logic [NSRC*WIDTH-1:0] src_bus_i,
  input  logic [SEL_W-1:0]      sel_i,
  output logic [WIDTH-1:0]      value_o,
  output logic                  oor_o
);
  localparam logic [SEL_W-1:0] SelZero = SEL_W'(NSRC + SEL_ZERO_OFS);
  localparam logic [SEL_W-1:0] SelOne  = SEL_W'(NSRC + SEL_ONE_OFS);
  localparam logic [SEL_W-1:0] SelOnes = SEL_W'(NSRC + SEL_ONES_OFS);

  always_comb begin
    value_o = '0;
    oor_o   = 1'b0;
    if (sel_i == SelZero) begin
      value_o = '0;
    end else if (sel_i == SelOne) begin
      value_o = WIDTH'(1);
    end else if (sel_i == SelOnes) begin
      value_o = '1;
    end else if (sel_i > SelOnes) begin
      oor_o = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (sel_i == SEL_W'(i)) value_o = src_bus_i[i*WIDTH +: WIDTH];
      end
    end
  end
endmodule

// File: rtl/alu_operand_stage.sv
// Registered two-operand staging for the ALU with a valid/ready pair handshake.
module alu_operand_stage
  import cpu_operand_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NSRC  = 6,
  parameter int unsigned SEL_W = $clog2(NSRC + 3)
) (
  input logic               clk,
  input logic               rst,
  alu_operand_stage_if.slave bus
);
  op_state_e        state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             op_valid_q;
  logic             sel_err_q, sel_err_d;

  logic [WIDTH-1:0] val_a, val_b;
  logic             oor_a, oor_b;
  logic             cap_en, cap_a, cap_b;

  operand_select #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC),
    .SEL_W (SEL_W)
  ) u_sel_a (
    .src_bus_i (bus.src_bus),
    .sel_i     (bus.sel_a),
    .value_o   (val_a),
    .oor_o     (oor_a)
  );

  operand_select #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC),
    .SEL_W (SEL_W)
  ) u_sel_b (
    .src_bus_i (bus.src_bus),
    .sel_i     (bus.sel_b),
    .value_o   (val_b),
    .oor_o     (oor_b)
  );

  // A stalled full pair blocks capture so the offered pair cannot be overrun.
  always_comb begin
    cap_en = !bus.flush && ((state_q != StFull) || bus.alu_ready);
    cap_a  = cap_en && bus.load_a;
    cap_b  = cap_en && bus.load_b;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: state_d = state_from_flags(cap_a, cap_b);
        StHaveA: state_d = state_from_flags(1'b1, cap_b);
        StHaveB: state_d = state_from_flags(cap_a, 1'b1);
        StFull:  state_d = bus.alu_ready ? state_from_flags(cap_a, cap_b) : StFull;
      endcase
    end
  end

  always_comb begin
    alu_a_d   = cap_a ? val_a : alu_a_q;
    alu_b_d   = cap_b ? val_b : alu_b_q;
    sel_err_d = sel_err_q | (cap_a & oor_a) | (cap_b & oor_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      op_valid_q <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      op_valid_q <= (state_d == StFull);
      sel_err_q  <= sel_err_d;
    end
  end

  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.op_valid = op_valid_q;
  assign bus.sel_err  = sel_err_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomised and directed checks of alu_operand_stage against a flag-based pair model.
module tb_alu_operand_stage;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned NSRC  = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] src [NSRC];
  bit         m_has_a, m_has_b, m_err;
  logic [7:0] m_a, m_b;

  alu_operand_stage_if #(.WIDTH(WIDTH), .NSRC(NSRC)) bus ();

  alu_operand_stage #(.WIDTH(WIDTH), .NSRC(NSRC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_val(input int sel, input logic [7:0] s0,
      input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3,
      input logic [7:0] s4, input logic [7:0] s5);
    case (sel)
      0: return s0;
      1: return s1;
      2: return s2;
      3: return s3;
      4: return s4;
      5: return s5;
      7: return 8'h01;
      8: return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  task automatic pack_src();
    for (int i = 0; i < NSRC; i++) bus.src_bus[i*8 +: 8] = src[i];
  endtask

  task automatic drive(input bit la, input int sa, input bit lb, input int sb,
                       input bit fl, input bit rdy);
    bus.load_a = la; bus.sel_a = 4'(sa);
    bus.load_b = lb; bus.sel_b = 4'(sb);
    bus.flush = fl; bus.alu_ready = rdy;
    pack_src();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_has_a = 0; m_has_b = 0; m_err = 0; m_a = 0; m_b = 0;
  endtask

  // Pair model: two "staged" flags and two values, updated from the inputs seen at the edge.
  task automatic model_edge();
    bit full;
    if (rst) begin
      model_reset();
      return;
    end
    full = m_has_a && m_has_b;
    if (bus.flush) begin
      m_has_a = 0; m_has_b = 0;
    end else if (!(full && !bus.alu_ready)) begin
      if (full) begin m_has_a = 0; m_has_b = 0; end
      if (bus.load_a) begin
        m_a = model_val(int'(bus.sel_a), src[0], src[1], src[2], src[3], src[4], src[5]);
        m_has_a = 1;
        if (bus.sel_a > 8) m_err = 1;
      end
      if (bus.load_b) begin
        m_b = model_val(int'(bus.sel_b), src[0], src[1], src[2], src[3], src[4], src[5]);
        m_has_b = 1;
        if (bus.sel_b > 8) m_err = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("alu_a", 32'(bus.alu_a), 32'(m_a));
    check("alu_b", 32'(bus.alu_b), 32'(m_b));
    check("op_valid", 32'(bus.op_valid), 32'(m_has_a && m_has_b));
    check("sel_err", 32'(bus.sel_err), 32'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    for (int i = 0; i < NSRC; i++) src[i] = 8'(8'h10 * i + 1);
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    check("reset_alu_a", 32'(bus.alu_a), 32'h0);
    check("reset_valid", 32'(bus.op_valid), 32'h0);
    check("reset_err", 32'(bus.sel_err), 32'h0);
    step();
    @(negedge clk); rst = 1'b0;

    // Split load: X then Y two cycles later.
    src[4] = 8'h12; src[5] = 8'h34;
    drive(1, 4, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    step();
    drive(0, 0, 1, 5, 0, 0); step();
    check("split_valid", 32'(bus.op_valid), 32'h1);
    check("split_a", 32'(bus.alu_a), 32'h12);
    check("split_b", 32'(bus.alu_b), 32'h34);

    // Stall: load while full and not ready is ignored.
    src[0] = 8'h77;
    drive(1, 0, 0, 0, 0, 0); step();
    check("stall_hold_a", 32'(bus.alu_a), 32'h12);
    src[1] = 8'h55;
    drive(0, 0, 1, 1, 0, 1); step();
    check("consume_valid", 32'(bus.op_valid), 32'h0);
    check("consume_b", 32'(bus.alu_b), 32'h55);

    // Constants, then an out-of-range code.
    drive(1, 8, 1, 7, 0, 0); step();
    check("const_a", 32'(bus.alu_a), 32'hFF);
    check("const_b", 32'(bus.alu_b), 32'h01);
    check("const_valid", 32'(bus.op_valid), 32'h1);
    drive(1, 9, 0, 0, 0, 1); step();
    check("oor_a", 32'(bus.alu_a), 32'h00);
    check("oor_err", 32'(bus.sel_err), 32'h1);
    drive(0, 0, 0, 0, 0, 0); step();
    check("err_sticky", 32'(bus.sel_err), 32'h1);

    // Flush beats a simultaneous load; alu_b keeps its value.
    drive(0, 0, 1, 5, 1, 0); step();
    check("flush_valid", 32'(bus.op_valid), 32'h0);
    check("flush_b", 32'(bus.alu_b), 32'h01);

    // Streaming: one pair per cycle with incrementing sources.
    for (int i = 0; i < 8; i++) begin
      src[4] = 8'(i + 8'h20); src[5] = 8'(i + 8'hA0);
      drive(1, 4, 1, 5, 0, 1); step();
      check("stream_valid", 32'(bus.op_valid), 32'h1);
      check("stream_a", 32'(bus.alu_a), 32'(i + 8'h20));
      check("stream_b", 32'(bus.alu_b), 32'(i + 8'hA0));
    end

    // Asynchronous reset while a pair is offered.
    src[4] = 8'h3C;
    drive(1, 4, 1, 5, 0, 1); step();
    check("pre_rst_a", 32'(bus.alu_a), 32'h3C);
    drive(0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_a", 32'(bus.alu_a), 32'h0);
    check("async_rst_b", 32'(bus.alu_b), 32'h0);
    check("async_rst_valid", 32'(bus.op_valid), 32'h0);
    check("async_rst_err", 32'(bus.sel_err), 32'h0);
    step();
    @(negedge clk); rst = 1'b0;

    // Random traffic, including occasional resets.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NSRC; i++) src[i] = 8'($urandom);
      drive($urandom_range(0, 1), int'($urandom_range(0, 9 + (($urandom_range(0, 7) == 0) ? 6 : 0))),
            $urandom_range(0, 1), int'($urandom_range(0, 8)),
            ($urandom_range(0, 15) == 0), $urandom_range(0, 1));
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
